rle_index_scanner: RTL and testbench

Parametrised successor to the fixed-width index scanner. It follows the run-length-compressed sample stream from the logic-analyser compressor and keeps the absolute uncompressed sample index. Over the old scanner it adds configurable sample width, save/restore of scanner state, explicit index load, a sticky wrap flag, and an armed target comparator that reports when playback reaches a given sample index. It sits between the compressed-stream reader and the trigger/seek logic.

---
 rtl/rle_index_scanner_if.sv | 37 +++
 rtl/rle_index_scanner.sv | 121 ++++++++++++
 tb/tb_rle_index_scanner.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/rle_index_scanner_if.sv
// Bus between the compressed-stream reader/seek logic and the RLE index scanner.
// Signal suffixes are named from the scanner's point of view.
interface rle_index_scanner_if #(
  parameter int SAMPLE_W = 16,
  parameter int INDEX_W  = 60
);
  logic [SAMPLE_W-1:0] sample_i;
  logic                sample_strobe_i;
  logic                clear_state_i;
  logic                state_load_i;
  logic [SAMPLE_W+1:0] state_in_i;
  logic                index_load_i;
  logic [INDEX_W-1:0]  index_in_i;
  logic [INDEX_W-1:0]  target_i;
  logic                target_arm_i;

  logic [INDEX_W-1:0]  index_o;
  logic [SAMPLE_W+1:0] scanner_state_o;
  logic                index_wrap_o;
  logic                target_armed_o;
  logic                target_hit_o;
  logic [INDEX_W-1:0]  hit_index_o;

  modport master (
    output sample_i, sample_strobe_i, clear_state_i, state_load_i, state_in_i,
           index_load_i, index_in_i, target_i, target_arm_i,
    input  index_o, scanner_state_o, index_wrap_o, target_armed_o,
           target_hit_o, hit_index_o
  );

  modport slave (
    input  sample_i, sample_strobe_i, clear_state_i, state_load_i, state_in_i,
           index_load_i, index_in_i, target_i, target_arm_i,
    output index_o, scanner_state_o, index_wrap_o, target_armed_o,
           target_hit_o, hit_index_o
  );
endinterface

// File: rtl/rle_index_scanner.sv
// RLE index scanner: follows a run-length-compressed sample stream and tracks
// the absolute uncompressed sample index, with save/restore, index load, a
// sticky wrap flag and an armed target comparator.
module rle_index_scanner #(
  parameter int SAMPLE_W = 16,
  parameter int INDEX_W  = 60
) (
  input logic                clk,
  input logic                rst,
  rle_index_scanner_if.slave bus
);

  typedef enum logic [1:0] {
    LIT0 = 2'b00,
    LIT1 = 2'b01,
    RUN  = 2'b10,
    ALT  = 2'b11
  } state_e;

  state_e              stateQ, stateD;
  logic [SAMPLE_W-1:0] lastSampleQ, lastSampleD;
  logic [INDEX_W-1:0]  indexQ, indexD;
  logic                wrapQ, wrapD;
  logic                armedQ, armedD;
  logic                hitQ, hitD;
  logic [INDEX_W-1:0]  hitIndexQ, hitIndexD;

  logic [INDEX_W-1:0]  increment;
  logic [INDEX_W:0]    indexSum;
  logic                armNow;
  logic                reached;

  // Decoder: next state, last literal and index/wrap, with loads taking priority
  always_comb begin
    stateD      = stateQ;
    lastSampleD = lastSampleQ;
    indexD      = indexQ;
    wrapD       = wrapQ;
    increment   = {{(INDEX_W-1){1'b0}}, 1'b1};
    if (stateQ == RUN) begin
      increment = {{(INDEX_W-SAMPLE_W){1'b0}}, bus.sample_i};
    end
    indexSum = {1'b0, indexQ} + {1'b0, increment};

    if (bus.sample_strobe_i) begin
      case (stateQ)
        LIT1: begin
          lastSampleD = bus.sample_i;
          if (bus.sample_i == lastSampleQ) begin
            stateD = RUN;
          end
        end
        RUN: begin
          if (!(&bus.sample_i)) begin
            stateD = LIT0;
          end
        end
        default: begin
          lastSampleD = bus.sample_i;
          stateD      = LIT1;
        end
      endcase
    end

    if (bus.state_load_i) begin
      stateD      = state_e'(bus.state_in_i[1:0]);
      lastSampleD = bus.state_in_i[SAMPLE_W+1:2];
    end else if (bus.clear_state_i) begin
      stateD = LIT0;
    end

    if (bus.index_load_i) begin
      indexD = bus.index_in_i;
      wrapD  = 1'b0;
    end else if (bus.sample_strobe_i) begin
      indexD = indexSum[INDEX_W-1:0];
      wrapD  = wrapQ | indexSum[INDEX_W];
    end
  end

  // Comparator: evaluated against the index value this edge will produce
  always_comb begin
    armNow    = armedQ | bus.target_arm_i;
    reached   = (indexD >= bus.target_i);
    hitD      = armNow & reached;
    armedD    = armNow & !reached;
    hitIndexD = hitIndexQ;
    if (hitD) begin
      hitIndexD = indexD;
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateQ      <= LIT0;
      lastSampleQ <= '0;
      indexQ      <= '0;
      wrapQ       <= 1'b0;
      armedQ      <= 1'b0;
      hitQ        <= 1'b0;
      hitIndexQ   <= '0;
    end else begin
      stateQ      <= stateD;
      lastSampleQ <= lastSampleD;
      indexQ      <= indexD;
      wrapQ       <= wrapD;
      armedQ      <= armedD;
      hitQ        <= hitD;
      hitIndexQ   <= hitIndexD;
    end
  end

  assign bus.index_o         = indexQ;
  assign bus.scanner_state_o = {lastSampleQ, stateQ};
  assign bus.index_wrap_o    = wrapQ;
  assign bus.target_armed_o  = armedQ;
  assign bus.target_hit_o    = hitQ;
  assign bus.hit_index_o     = hitIndexQ;

endmodule

// File: tb/tb_rle_index_scanner.sv
// Directed self-checking bench for rle_index_scanner (SAMPLE_W=16, INDEX_W=20).
module tb_rle_index_scanner;

  localparam int SW = 16;
  localparam int IW = 20;

  logic clk;
  logic rst;
  int   compareCount;
  int   failCount;

  rle_index_scanner_if #(.SAMPLE_W(SW), .INDEX_W(IW)) bus ();

  rle_index_scanner #(.SAMPLE_W(SW), .INDEX_W(IW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    compareCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // One clock edge, sample #1 later, then drop every one-shot control
  task automatic tick();
    @(posedge clk);
    #1;
    bus.sample_strobe_i = 1'b0;
    bus.clear_state_i   = 1'b0;
    bus.state_load_i    = 1'b0;
    bus.index_load_i    = 1'b0;
    bus.target_arm_i    = 1'b0;
  endtask

  task automatic applyStimulus(input logic [SW-1:0] word);
    bus.sample_i        = word;
    bus.sample_strobe_i = 1'b1;
    tick();
  endtask

  // Asynchronous reset pulse, checked before any clock edge arrives
  task automatic pulseReset(input string tag);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput({tag, "_index"}, 64'(bus.index_o), 64'd0);
    checkOutput({tag, "_state"}, 64'(bus.scanner_state_o), 64'd0);
    checkOutput({tag, "_wrap"}, 64'(bus.index_wrap_o), 64'd0);
    checkOutput({tag, "_armed"}, 64'(bus.target_armed_o), 64'd0);
    checkOutput({tag, "_hit"}, 64'(bus.target_hit_o), 64'd0);
    checkOutput({tag, "_hitidx"}, 64'(bus.hit_index_o), 64'd0);
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    compareCount = 0;
    failCount    = 0;
    rst                 = 1'b0;
    bus.sample_i        = '0;
    bus.sample_strobe_i = 1'b0;
    bus.clear_state_i   = 1'b0;
    bus.state_load_i    = 1'b0;
    bus.state_in_i      = '0;
    bus.index_load_i    = 1'b0;
    bus.index_in_i      = '0;
    bus.target_i        = '1;
    bus.target_arm_i    = 1'b0;

    pulseReset("reset");

    // Literals
    applyStimulus(16'h0001);
    checkOutput("lit1_index", 64'(bus.index_o), 64'd1);
    checkOutput("lit1_state", 64'(bus.scanner_state_o[1:0]), 64'b01);
    applyStimulus(16'h0002);
    checkOutput("lit2_index", 64'(bus.index_o), 64'd2);
    checkOutput("lit2_state", 64'(bus.scanner_state_o[1:0]), 64'b01);
    applyStimulus(16'h0003);
    checkOutput("lit3_index", 64'(bus.index_o), 64'd3);
    checkOutput("lit3_sstate", 64'(bus.scanner_state_o), {46'd0, 16'h0003, 2'b01});

    // Short run
    pulseReset("rst_short");
    applyStimulus(16'hAAAA);
    checkOutput("short1_index", 64'(bus.index_o), 64'd1);
    applyStimulus(16'hAAAA);
    checkOutput("short2_index", 64'(bus.index_o), 64'd2);
    checkOutput("short2_state", 64'(bus.scanner_state_o[1:0]), 64'b10);
    applyStimulus(16'h0005);
    checkOutput("short3_index", 64'(bus.index_o), 64'd7);
    checkOutput("short3_sstate", 64'(bus.scanner_state_o), {46'd0, 16'hAAAA, 2'b00});
    applyStimulus(16'h1234);
    checkOutput("short4_index", 64'(bus.index_o), 64'd8);
    checkOutput("short4_sstate", 64'(bus.scanner_state_o), {46'd0, 16'h1234, 2'b01});

    // Extended run
    pulseReset("rst_ext");
    applyStimulus(16'h0005);
    applyStimulus(16'h0005);
    checkOutput("ext2_index", 64'(bus.index_o), 64'd2);
    applyStimulus(16'hFFFF);
    checkOutput("ext3_index", 64'(bus.index_o), 64'd65537);
    checkOutput("ext3_state", 64'(bus.scanner_state_o[1:0]), 64'b10);
    applyStimulus(16'hFFFF);
    checkOutput("ext4_index", 64'(bus.index_o), 64'd131072);
    checkOutput("ext4_state", 64'(bus.scanner_state_o[1:0]), 64'b10);
    applyStimulus(16'h0003);
    checkOutput("ext5_index", 64'(bus.index_o), 64'd131075);
    checkOutput("ext5_state", 64'(bus.scanner_state_o[1:0]), 64'b00);

    // Target comparator
    pulseReset("rst_tgt");
    bus.index_load_i = 1'b1;
    bus.index_in_i   = 20'd95;
    bus.target_i     = 20'd100;
    bus.target_arm_i = 1'b1;
    tick();
    checkOutput("arm_armed", 64'(bus.target_armed_o), 64'd1);
    checkOutput("arm_hit", 64'(bus.target_hit_o), 64'd0);
    applyStimulus(16'h0007);
    checkOutput("tgt1_index", 64'(bus.index_o), 64'd96);
    applyStimulus(16'h0007);
    checkOutput("tgt2_index", 64'(bus.index_o), 64'd97);
    applyStimulus(16'h0002);
    checkOutput("tgt3_index", 64'(bus.index_o), 64'd99);
    checkOutput("tgt3_hit", 64'(bus.target_hit_o), 64'd0);
    checkOutput("tgt3_armed", 64'(bus.target_armed_o), 64'd1);
    applyStimulus(16'h0009);
    checkOutput("tgt4_index", 64'(bus.index_o), 64'd100);
    checkOutput("tgt4_hit", 64'(bus.target_hit_o), 64'd1);
    checkOutput("tgt4_hitidx", 64'(bus.hit_index_o), 64'd100);
    checkOutput("tgt4_armed", 64'(bus.target_armed_o), 64'd0);
    applyStimulus(16'h0009);
    checkOutput("tgt5_index", 64'(bus.index_o), 64'd101);
    checkOutput("tgt5_hit", 64'(bus.target_hit_o), 64'd0);
    bus.target_arm_i = 1'b1;
    tick();
    checkOutput("rearm_hit", 64'(bus.target_hit_o), 64'd1);
    checkOutput("rearm_hitidx", 64'(bus.hit_index_o), 64'd101);
    checkOutput("rearm_armed", 64'(bus.target_armed_o), 64'd0);
    tick();
    checkOutput("rearm_pulse_end", 64'(bus.target_hit_o), 64'd0);

    // Wrap
    bus.index_load_i  = 1'b1;
    bus.index_in_i    = 20'hFFFFE;
    bus.clear_state_i = 1'b1;
    bus.target_i      = '1;
    tick();
    applyStimulus(16'h0001);
    checkOutput("wrap1_index", 64'(bus.index_o), 64'hFFFFF);
    checkOutput("wrap1_flag", 64'(bus.index_wrap_o), 64'd0);
    applyStimulus(16'h0002);
    checkOutput("wrap2_index", 64'(bus.index_o), 64'h00000);
    checkOutput("wrap2_flag", 64'(bus.index_wrap_o), 64'd1);
    bus.index_load_i = 1'b1;
    bus.index_in_i   = 20'd5;
    tick();
    checkOutput("wrapclr_flag", 64'(bus.index_wrap_o), 64'd0);
    checkOutput("wrapclr_index", 64'(bus.index_o), 64'd5);

    // index_load with strobe: increment dropped, decoder still advances
    bus.index_load_i = 1'b1;
    bus.index_in_i   = 20'd50;
    applyStimulus(16'h0002);
    checkOutput("ldstb_index", 64'(bus.index_o), 64'd50);
    checkOutput("ldstb_state", 64'(bus.scanner_state_o[1:0]), 64'b10);

    // Save / restore
    pulseReset("rst_save");
    applyStimulus(16'h00AA);
    applyStimulus(16'h00AA);
    applyStimulus(16'hFFFF);
    checkOutput("save_sstate", 64'(bus.scanner_state_o), {46'd0, 16'h00AA, 2'b10});
    checkOutput("save_index", 64'(bus.index_o), 64'd65537);
    pulseReset("rst_mid");
    bus.state_load_i = 1'b1;
    bus.state_in_i   = {16'h00AA, 2'b10};
    bus.index_load_i = 1'b1;
    bus.index_in_i   = 20'd65537;
    tick();
    checkOutput("restore_sstate", 64'(bus.scanner_state_o), {46'd0, 16'h00AA, 2'b10});
    applyStimulus(16'h0004);
    checkOutput("resume_index", 64'(bus.index_o), 64'd65541);
    checkOutput("resume_state", 64'(bus.scanner_state_o[1:0]), 64'b00);

    // clear_state with a strobe in RUN
    applyStimulus(16'h0010);
    applyStimulus(16'h0010);
    checkOutput("clr_pre_state", 64'(bus.scanner_state_o[1:0]), 64'b10);
    bus.clear_state_i = 1'b1;
    applyStimulus(16'h0003);
    checkOutput("clr_index", 64'(bus.index_o), 64'd65546);
    checkOutput("clr_sstate", 64'(bus.scanner_state_o), {46'd0, 16'h0010, 2'b00});

    // State 11 from state_load decodes as LIT0
    bus.state_load_i = 1'b1;
    bus.state_in_i   = {16'h0007, 2'b11};
    tick();
    applyStimulus(16'h0009);
    checkOutput("alt_index", 64'(bus.index_o), 64'd65547);
    checkOutput("alt_sstate", 64'(bus.scanner_state_o), {46'd0, 16'h0009, 2'b01});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule
